vlsu_l1_port_arbiter: RTL



---
 rtl/vlsu_l1_port_arbiter_pkg.sv | 8 +
 rtl/vlsu_l1_port_arbiter_fifo.sv | 47 ++++
 rtl/vlsu_l1_port_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/vlsu_l1_port_arbiter_pkg.sv
// vlsu_l1_port_arbiter_pkg: shared types and constants for the VLSU L1 port arbiter
package vlsu_l1_port_arbiter_pkg;
  localparam int unsigned VlsuL1MaxOutstanding = 4;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vlsu_l1_port_arbiter_fifo.sv
// vlsu_l1_port_arbiter_fifo: registered-output ID FIFO tracking in-order read responses
module vlsu_l1_port_arbiter_fifo
  import vlsu_l1_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o
);
  localparam int unsigned PtrW = idx_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  do_push, do_pop;
  always_comb begin
    do_pop  = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != Full) | do_pop);
    wptr_d  = do_push ? ((wptr_q == LastPtr) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d  = do_pop ? ((rptr_q == LastPtr) ? '0 : rptr_q + 1'b1) : rptr_q;
    cnt_d   = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end
  assign data_o  = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/vlsu_l1_port_arbiter.sv
// vlsu_l1_port_arbiter: round-robin sharing of one L1 D$ port among VLSU requesters,
// with grant-pending lock, bounded outstanding reads and in-order response routing.
module vlsu_l1_port_arbiter
  import vlsu_l1_port_arbiter_pkg::*;
#(
  parameter int unsigned NrReq          = 2,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = VlsuL1MaxOutstanding
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NrReq-1:0]               req_valid_i,
  input  logic [NrReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NrReq-1:0]               req_we_i,
  input  logic [NrReq*DataWidth-1:0]     req_wdata_i,
  input  logic [NrReq*DataWidth/8-1:0]   req_be_i,
  output logic [NrReq-1:0]               req_gnt_o,
  output logic [NrReq-1:0]               rsp_valid_o,
  output logic [DataWidth-1:0]           rsp_rdata_o,
  output logic                           mem_req_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic                           mem_we_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  output logic [DataWidth/8-1:0]         mem_be_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [DataWidth-1:0]           mem_rdata_i,
  output logic                           busy_o,
  output logic                           err_o
);
  localparam int unsigned IdxW  = idx_width(NrReq);
  localparam int unsigned IdxW1 = IdxW + 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeW   = DataWidth / 8;
  localparam logic [IdxW:0]   NrReqW  = IdxW1'(NrReq);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrReq - 1);
  localparam logic [CntW-1:0] MaxOut  = CntW'(MaxOutstanding);
  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d, sel_q, sel_d, sel, pick, head;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic            err_q, err_d;
  logic [NrReq-1:0] elig;
  logic [IdxW:0]   cand;
  logic            found, grant, push, pop, fifo_empty;
  // Reads past the outstanding limit are masked out so writes can still win
  always_comb begin
    elig  = req_valid_i & (req_we_i | {NrReq{outstanding_q < MaxOut}});
    pick  = rr_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NrReq; k++) begin
      cand = {1'b0, rr_q} + IdxW1'(k);
      if (cand >= NrReqW) cand = cand - NrReqW;
      if (!found && elig[cand[IdxW-1:0]]) begin
        pick  = cand[IdxW-1:0];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    sel           = (state_q == LOCKED) ? sel_q : pick;
    mem_req_o     = (state_q == LOCKED) ? req_valid_i[sel_q] : found;
    grant         = mem_req_o & mem_gnt_i;
    if (state_q == IDLE && mem_req_o && !mem_gnt_i) begin
      state_d = LOCKED;
      sel_d   = sel;
    end else if (state_q == LOCKED && mem_gnt_i) begin
      state_d = IDLE;
    end
    rr_d          = grant ? ((sel == LastIdx) ? '0 : sel + 1'b1) : rr_q;
    push          = grant & ~req_we_i[sel];
    pop           = mem_rvalid_i & ~fifo_empty;
    outstanding_d = outstanding_q + CntW'(push) - CntW'(pop);
    err_d         = err_q | (mem_rvalid_i & fifo_empty);
    req_gnt_o     = '0;
    rsp_valid_o   = '0;
    for (int i = 0; i < NrReq; i++) begin
      req_gnt_o[i]   = grant & (sel == IdxW'(i));
      rsp_valid_o[i] = pop & (head == IdxW'(i));
    end
  end
  assign mem_addr_o  = mem_req_o ? req_addr_i[sel*AddrWidth +: AddrWidth] : '0;
  assign mem_we_o    = mem_req_o & req_we_i[sel];
  assign mem_wdata_o = mem_req_o ? req_wdata_i[sel*DataWidth +: DataWidth] : '0;
  assign mem_be_o    = mem_req_o ? req_be_i[sel*BeW +: BeW] : '0;
  assign rsp_rdata_o = mem_rdata_i;
  assign busy_o      = (outstanding_q != '0) | (|req_valid_i);
  assign err_o       = err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      sel_q         <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      sel_q         <= sel_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end
  vlsu_l1_port_arbiter_fifo #(
    .DEPTH      (MaxOutstanding),
    .DATA_WIDTH (IdxW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sel),
    .data_o  (head),
    .empty_o (fifo_empty)
  );
endmodule
